clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles target_rst is held asserted before the clock selects change.
REQ-002 Parameter MMCM_RST_CYCLES, default 8: width of the mmcm_rst pulse.
REQ-003 Parameter SETTLE_CYCLES, default 64: cycles after the clock is stable before target_rst is released.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536: lock-wait limit, used only when the watchdog is compiled in.
REQ-005 Parameter CNT_W, default 17: width of the shared down-counter; SHALL hold the largest cycle parameter.
REQ-006 usb_clk  in  1  sole clock, free-running, independent of the selected target clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req  in  1  single-cycle switch request.
REQ-009 req_src  in  1  requested source: 0 = pll_clk1, 1 = tio_clkin; sampled with req.
REQ-010 req_bypass  in  1  requested bypass: 1 = bypass MMCM; sampled with req.
REQ-011 mmcm_locked  in  1  MMCM lock, asynchronous to usb_clk.
REQ-012 clk_src_sel  out  1  drives the first-stage source mux select.
REQ-013 pll_bypass  out  1  drives the MMCM bypass mux select.
REQ-014 mmcm_rst  out  1  MMCM reset.
REQ-015 target_rst  out  1  reset to logic clocked by the selected clock.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on completion of a sequence.
REQ-018 lock_err  out  1  sticky lock-timeout flag.
REQ-019 state  out  3  current FSM state encoding, for debug readback.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, HOLD, SWITCH, MMCM_RST, WAIT_LOCK, SETTLE, DONE.
REQ-021 mmcm_locked SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (lock_s).
REQ-022 In IDLE, req=1 SHALL latch req_src and req_bypass, clear lock_err, and enter HOLD on the next cycle; req in any other state SHALL be ignored.
REQ-023 HOLD SHALL assert target_rst and last exactly HOLD_CYCLES cycles, then enter SWITCH.
REQ-024 SWITCH SHALL last one cycle and update clk_src_sel and pll_bypass from the latched values; it SHALL go to SETTLE if bypass=1, else to MMCM_RST.
REQ-025 MMCM_RST SHALL assert mmcm_rst for exactly MMCM_RST_CYCLES cycles, then enter WAIT_LOCK.
REQ-026 WAIT_LOCK SHALL enter SETTLE on the first cycle lock_s=1.
REQ-027 SETTLE SHALL last SETTLE_CYCLES cycles with target_rst still asserted, then enter DONE.
REQ-028 DONE SHALL deassert target_rst, pulse done for one cycle, and return to IDLE.
REQ-029 A single CNT_W-bit down-counter SHALL be loaded on each timed-state entry; the state exits on the cycle the counter equals 1, with no wrap.
REQ-030 If lock_s falls in IDLE while pll_bypass=0, the FSM SHALL assert target_rst and enter MMCM_RST (relock without a select change).
REQ-031 If req and a lock_s fall occur in the same IDLE cycle, req SHALL take priority.
REQ-032 A parameter value of 0 for any cycle count SHALL be treated as 1.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, clk_src_sel=0, pll_bypass=1, mmcm_rst=0, target_rst=1, busy=0, done=0, lock_err=0, counter=0, and clear the synchronizer; this applies mid-sequence as well.
REQ-034 target_rst SHALL remain asserted after reset until the first DONE.

Configuration
REQ-035 Macro CLK_SWITCH_TIMEOUT_EN defined: if WAIT_LOCK lasts TIMEOUT_CYCLES cycles without lock_s, the block SHALL set lock_err, force pll_bypass=1, and enter SETTLE (fallback to the unbuffered clock).
REQ-036 Macro CLK_SWITCH_TIMEOUT_EN undefined: WAIT_LOCK SHALL wait indefinitely and lock_err SHALL be tied to 0.

Verification
REQ-037 Power-on: reset pulse -> pll_bypass=1, clk_src_sel=0, target_rst=1, state=IDLE, busy=0.
REQ-038 Bypass switch: req with src=1, bypass=1 -> HOLD 16 cycles, clk_src_sel=1, mmcm_rst never asserted, SETTLE 64 cycles, done pulse, target_rst=0; total 83 cycles from req to done.
REQ-039 PLL switch: req with src=0, bypass=0, and mmcm_locked rising 100 cycles after mmcm_rst falls -> mmcm_rst high for exactly 8 cycles, SETTLE starts 2-3 cycles after the lock edge, done pulse.
REQ-040 Timeout (macro defined, TIMEOUT_CYCLES=32): PLL request with mmcm_locked held at 0 -> lock_err=1 and pll_bypass=1 after 32 WAIT_LOCK cycles, then SETTLE and done; the next req clears lock_err.
REQ-041 Lock loss in IDLE (PLL mode): drop mmcm_locked -> target_rst=1 and mmcm_rst pulse follow; a second req during busy is ignored.
REQ-042 Reset mid-WAIT_LOCK -> immediate return to IDLE with all reset values.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Glitch-safe clock source / MMCM bypass switch sequencer, clocked by the free-running usb_clk.
// Optional lock-wait watchdog compiled in with `define CLK_SWITCH_TIMEOUT_EN.
module clk_switch_ctrl #(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned MMCM_RST_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES   = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       usb_clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_src,
  input  logic       req_bypass,
  input  logic       mmcm_locked,
  output logic       clk_src_sel,
  output logic       pll_bypass,
  output logic       mmcm_rst,
  output logic       target_rst,
  output logic       busy,
  output logic       done,
  output logic       lock_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    SWITCH    = 3'd2,
    MMCM_RST  = 3'd3,
    WAIT_LOCK = 3'd4,
    SETTLE    = 3'd5,
    DONE      = 3'd6
  } state_e;

  // Zero-length timings collapse to a single cycle
  localparam int unsigned HOLD_LD   = (HOLD_CYCLES     == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned MRST_LD   = (MMCM_RST_CYCLES == 0) ? 1 : MMCM_RST_CYCLES;
  localparam int unsigned SETTLE_LD = (SETTLE_CYCLES   == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned TO_LD     = (TIMEOUT_CYCLES  == 0) ? 1 : TIMEOUT_CYCLES;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lock_sync_q, lock_sync_d;
  logic             lock_prev_q, lock_prev_d;
  logic             src_lat_q, src_lat_d;
  logic             byp_lat_q, byp_lat_d;
  logic             clk_src_sel_q, clk_src_sel_d;
  logic             pll_bypass_q, pll_bypass_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             target_rst_q, target_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lock_s;
  logic             lock_fall;
  logic             cnt_last;
`ifdef CLK_SWITCH_TIMEOUT_EN
  logic             lock_err_q, lock_err_d;
`endif

  assign lock_s    = lock_sync_q[1];
  assign lock_fall = lock_prev_q & ~lock_s;
  assign cnt_last  = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lock_sync_d   = {lock_sync_q[0], mmcm_locked};
    lock_prev_d   = lock_s;
    src_lat_d     = src_lat_q;
    byp_lat_d     = byp_lat_q;
    clk_src_sel_d = clk_src_sel_q;
    pll_bypass_d  = pll_bypass_q;
    target_rst_d  = target_rst_q;
`ifdef CLK_SWITCH_TIMEOUT_EN
    lock_err_d    = lock_err_q;
`endif

    // Free-running decrement that parks at 1 (or 0 after reset); loads below override it
    if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (req) begin
          src_lat_d    = req_src;
          byp_lat_d    = req_bypass;
          target_rst_d = 1'b1;
          cnt_d        = CNT_W'(HOLD_LD);
          state_d      = HOLD;
`ifdef CLK_SWITCH_TIMEOUT_EN
          lock_err_d   = 1'b0;
`endif
        end else if (lock_fall && !pll_bypass_q) begin
          target_rst_d = 1'b1;
          cnt_d        = CNT_W'(MRST_LD);
          state_d      = MMCM_RST;
        end
      end
      HOLD: begin
        if (cnt_last) begin
          clk_src_sel_d = src_lat_q;
          pll_bypass_d  = byp_lat_q;
          state_d       = SWITCH;
        end
      end
      SWITCH: begin
        if (byp_lat_q) begin
          cnt_d   = CNT_W'(SETTLE_LD);
          state_d = SETTLE;
        end else begin
          cnt_d   = CNT_W'(MRST_LD);
          state_d = MMCM_RST;
        end
      end
      MMCM_RST: begin
        if (cnt_last) begin
          cnt_d   = CNT_W'(TO_LD);
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          cnt_d   = CNT_W'(SETTLE_LD);
          state_d = SETTLE;
        end
`ifdef CLK_SWITCH_TIMEOUT_EN
        else if (cnt_last) begin
          // Give up on the MMCM and run from the unbuffered source
          lock_err_d   = 1'b1;
          pll_bypass_d = 1'b1;
          cnt_d        = CNT_W'(SETTLE_LD);
          state_d      = SETTLE;
        end
`endif
      end
      SETTLE: begin
        if (cnt_last) begin
          target_rst_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mmcm_rst_d = (state_d == MMCM_RST);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lock_sync_q   <= 2'b00;
      lock_prev_q   <= 1'b0;
      src_lat_q     <= 1'b0;
      byp_lat_q     <= 1'b1;
      clk_src_sel_q <= 1'b0;
      pll_bypass_q  <= 1'b1;
      mmcm_rst_q    <= 1'b0;
      target_rst_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_sync_q   <= lock_sync_d;
      lock_prev_q   <= lock_prev_d;
      src_lat_q     <= src_lat_d;
      byp_lat_q     <= byp_lat_d;
      clk_src_sel_q <= clk_src_sel_d;
      pll_bypass_q  <= pll_bypass_d;
      mmcm_rst_q    <= mmcm_rst_d;
      target_rst_q  <= target_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef CLK_SWITCH_TIMEOUT_EN
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) lock_err_q <= 1'b0;
    else       lock_err_q <= lock_err_d;
  end
  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  assign clk_src_sel = clk_src_sel_q;
  assign pll_bypass  = pll_bypass_q;
  assign mmcm_rst    = mmcm_rst_q;
  assign target_rst  = target_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state       = state_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl; watchdog scenario runs when CLK_SWITCH_TIMEOUT_EN is defined.
module tb_clk_switch_ctrl;

  logic       usb_clk = 1'b0;
  logic       reset;
  logic       req;
  logic       req_src;
  logic       req_bypass;
  logic       mmcm_locked;
  logic       clk_src_sel;
  logic       pll_bypass;
  logic       mmcm_rst;
  logic       target_rst;
  logic       busy;
  logic       done;
  logic       lock_err;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_HOLD = 3'd1, S_SWITCH = 3'd2, S_MRST = 3'd3,
                         S_WAIT = 3'd4, S_SETTLE = 3'd5, S_DONE = 3'd6;

  clk_switch_ctrl #(
    .HOLD_CYCLES    (16),
    .MMCM_RST_CYCLES(8),
    .SETTLE_CYCLES  (64),
    .TIMEOUT_CYCLES (32),
    .CNT_W          (17)
  ) dut (
    .usb_clk    (usb_clk),
    .reset      (reset),
    .req        (req),
    .req_src    (req_src),
    .req_bypass (req_bypass),
    .mmcm_locked(mmcm_locked),
    .clk_src_sel(clk_src_sel),
    .pll_bypass (pll_bypass),
    .mmcm_rst   (mmcm_rst),
    .target_rst (target_rst),
    .busy       (busy),
    .done       (done),
    .lock_err   (lock_err),
    .state      (state)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  // Advance until state matches or the budget runs out; expiry shows up as a failed check
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic mmcm_pulse_width(input string tag);
    int w = 0;
    wait_state(S_MRST, 100, {tag, "_enter"});
    while (mmcm_rst === 1'b1 && w < 50) begin
      w++;
      tick();
    end
    check({tag, "_width"}, 32'(w), 32'd8);
  endtask

  initial begin
    int cyc;
    int n;
    logic mmcm_seen;

    reset = 1'b1; req = 1'b0; req_src = 1'b0; req_bypass = 1'b0; mmcm_locked = 1'b0;
    repeat (3) tick();

    // Power-on values
    check("por_state", 32'(state), 32'(S_IDLE));
    check("por_bypass", 32'(pll_bypass), 32'd1);
    check("por_src", 32'(clk_src_sel), 32'd0);
    check("por_trst", 32'(target_rst), 32'd1);
    check("por_busy", 32'(busy), 32'd0);
    check("por_mrst", 32'(mmcm_rst), 32'd0);
    check("por_done", 32'(done), 32'd0);
    check("por_lerr", 32'(lock_err), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle_trst_held", 32'(target_rst), 32'd1);

    // Bypass switch to tio_clkin
    req = 1'b1; req_src = 1'b1; req_bypass = 1'b1;
    tick();
    req = 1'b0;
    cyc = 1;
    mmcm_seen = 1'b0;
    check("byp_hold_entry", 32'(state), 32'(S_HOLD));
    check("byp_busy", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 200) begin
      if (mmcm_rst === 1'b1) mmcm_seen = 1'b1;
      if (cyc == 16) check("byp_hold_last", 32'(state), 32'(S_HOLD));
      if (cyc == 17) begin
        check("byp_switch", 32'(state), 32'(S_SWITCH));
        check("byp_src_sel", 32'(clk_src_sel), 32'd1);
      end
      if (cyc == 18) check("byp_settle", 32'(state), 32'(S_SETTLE));
      if (cyc == 81) check("byp_settle_trst", 32'(target_rst), 32'd1);
      tick();
      cyc++;
    end
    check("byp_total_cycles", 32'(cyc + 1), 32'd83);
    check("byp_no_mmcm_rst", 32'(mmcm_seen), 32'd0);
    check("byp_trst_off", 32'(target_rst), 32'd0);
    check("byp_bypass", 32'(pll_bypass), 32'd1);
    tick();
    check("byp_done_pulse", 32'(done), 32'd0);
    check("byp_back_idle", 32'(state), 32'(S_IDLE));
    check("byp_busy_off", 32'(busy), 32'd0);

    // PLL switch, lock arrives 100 cycles after mmcm_rst falls
    req = 1'b1; req_src = 1'b0; req_bypass = 1'b0;
    tick();
    req = 1'b0;
    check("pll_hold_trst", 32'(target_rst), 32'd1);
    mmcm_pulse_width("pll_mrst");
    check("pll_wait", 32'(state), 32'(S_WAIT));
    check("pll_bypass_off", 32'(pll_bypass), 32'd0);
    check("pll_src_sel", 32'(clk_src_sel), 32'd0);
    repeat (99) tick();
    check("pll_still_wait", 32'(state), 32'(S_WAIT));
    mmcm_locked = 1'b1;
    n = 0;
    while (state !== S_SETTLE && n < 10) begin
      tick();
      n++;
    end
    check("pll_lock_latency", 32'(n >= 2 && n <= 3), 32'd1);
    wait_state(S_DONE, 100, "pll_done_state");
    check("pll_done", 32'(done), 32'd1);
    check("pll_trst_off", 32'(target_rst), 32'd0);

    // Lock loss in IDLE triggers relock; req while busy is ignored
    tick();
    mmcm_locked = 1'b0;
    wait_state(S_MRST, 6, "loss_relock");
    check("loss_trst", 32'(target_rst), 32'd1);
    check("loss_mrst", 32'(mmcm_rst), 32'd1);
    req = 1'b1; req_src = 1'b1; req_bypass = 1'b1;
    tick();
    req = 1'b0;
    check("loss_req_ignored", 32'(state), 32'(S_MRST));
    wait_state(S_WAIT, 20, "loss_wait");
    check("loss_src_kept", 32'(clk_src_sel), 32'd0);
    mmcm_locked = 1'b1;
    wait_state(S_DONE, 100, "loss_done");
    check("loss_bypass_kept", 32'(pll_bypass), 32'd0);
    repeat (3) tick();

    // req coinciding with a lock fall in IDLE wins
    mmcm_locked = 1'b0;
    tick();
    tick();
    req = 1'b1; req_src = 1'b0; req_bypass = 1'b0;
    tick();
    req = 1'b0;
    check("prio_req_wins", 32'(state), 32'(S_HOLD));

    // Asynchronous reset in WAIT_LOCK
    wait_state(S_WAIT, 100, "rst_reach_wait");
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_bypass", 32'(pll_bypass), 32'd1);
    check("rst_trst", 32'(target_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_src", 32'(clk_src_sel), 32'd0);
    check("rst_mrst", 32'(mmcm_rst), 32'd0);
    @(negedge usb_clk);
    reset = 1'b0;
    repeat (2) tick();
    check("rst_stay_idle", 32'(state), 32'(S_IDLE));

`ifdef CLK_SWITCH_TIMEOUT_EN
    // Watchdog fallback to bypass
    req = 1'b1; req_src = 1'b0; req_bypass = 1'b0;
    tick();
    req = 1'b0;
    wait_state(S_WAIT, 100, "to_reach_wait");
    n = 0;
    while (state === S_WAIT && n < 100) begin
      tick();
      n++;
    end
    check("to_wait_cycles", 32'(n), 32'd32);
    check("to_settle", 32'(state), 32'(S_SETTLE));
    check("to_lock_err", 32'(lock_err), 32'd1);
    check("to_bypass", 32'(pll_bypass), 32'd1);
    wait_state(S_DONE, 100, "to_done");
    check("to_err_sticky", 32'(lock_err), 32'd1);
    tick();
    req = 1'b1; req_src = 1'b1; req_bypass = 1'b1;
    tick();
    req = 1'b0;
    check("to_err_cleared", 32'(lock_err), 32'd0);
    wait_state(S_DONE, 200, "to_second_done");
`else
    // Without the watchdog WAIT_LOCK waits forever
    req = 1'b1; req_src = 1'b0; req_bypass = 1'b0;
    tick();
    req = 1'b0;
    wait_state(S_WAIT, 100, "nto_reach_wait");
    repeat (40) tick();
    check("nto_still_wait", 32'(state), 32'(S_WAIT));
    check("nto_lock_err", 32'(lock_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
